// File: rtl/ram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_stream_reader_pkg
//  Description : Shared types and constants for the RAM stream reader. This
//                file holds the FSM state encoding and the skid-buffer depth
//                used by the top level and by stream_skid_fifo.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two entries cover the one-cycle RAM read latency plus one word of
    // backpressure slack, which is enough to sustain one word per cycle.
    localparam int unsigned C_SKID_DEPTH = 2;
    localparam int unsigned C_SKID_CNT_W = $clog2(C_SKID_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/ram_stream_reader_stream_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_fifo
//  Description : Two-entry synchronous FIFO used as a skid buffer behind a
//                registered-read RAM. A push and a pop in the same cycle are
//                both honoured, including when the FIFO is full.
//  Ports       : clk, rst (sync, active-high)
//                i_push / i_data  : write side
//                i_pop            : read side, ignored when empty
//                o_data           : head entry (stable until popped)
//                o_full / o_empty : occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [C_SKID_CNT_W-1:0] c_full_cnt = C_SKID_CNT_W'(C_SKID_DEPTH);
    localparam logic [C_SKID_CNT_W-1:0] c_one      = C_SKID_CNT_W'(1);

    logic [DATA_WIDTH-1:0]   r_mem [C_SKID_DEPTH];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [C_SKID_CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full_cnt);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
            for (int i = 0; i < C_SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_stream_reader
//  Description : Walks a contiguous address range on the read port of the
//                character/data RAM and emits each word on a valid/ready
//                stream. Reads are credit-limited so the 2-entry skid buffer
//                never overflows, while sustaining one word per cycle.
//  Ports       : clk, resetn (sync, active-low)
//                start, base_addr, length : transfer command (taken in IDLE)
//                busy, done               : transfer status
//                ren_b, addr_b, dout_b    : RAM read port B
//                m_valid, m_ready, m_data : output stream
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ren_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] dout_b,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    localparam logic [ADDR_WIDTH:0] c_cnt_one = (ADDR_WIDTH+1)'(1);
    localparam logic [2:0]          c_credits = 3'(C_SKID_DEPTH);

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addr_last;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issued;
    logic [ADDR_WIDTH:0]   r_sent;
    logic                  r_inflight;

    logic                  w_rst;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [2:0]            w_occ;
    logic [2:0]            w_credit_used;
    logic                  w_can_issue;
    logic [ADDR_WIDTH-1:0] w_issue_addr;

    assign w_rst   = ~resetn;
    assign m_valid = ~w_fifo_empty;
    assign w_pop   = m_valid && m_ready;

    // Slots committed to words: buffered + in flight, less the head that is
    // leaving this very cycle. Counting the departing head as free is what
    // lets the reader keep one read in flight per cycle at full rate.
    assign w_occ         = w_fifo_full ? 3'd2 : (w_fifo_empty ? 3'd0 : 3'd1);
    assign w_credit_used = w_occ + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_can_issue   = (r_issued < r_len) && (w_credit_used < c_credits);

    // Truncation to ADDR_WIDTH gives the wrap from the top address to 0.
    assign w_issue_addr  = r_base + r_issued[ADDR_WIDTH-1:0];
    assign addr_b        = ren_b ? w_issue_addr : r_addr_last;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        ren_b       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (length == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                ren_b = w_can_issue;
                if (w_pop && (r_sent == (r_len - c_cnt_one))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_base      <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_sent      <= '0;
            r_addr_last <= '0;
            r_inflight  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_base   <= base_addr;
                r_len    <= length;
                r_issued <= '0;
                r_sent   <= '0;
            end
            if (ren_b) begin
                r_issued    <= r_issued + c_cnt_one;
                r_addr_last <= w_issue_addr;
            end
            if (w_pop) begin
                r_sent <= r_sent + c_cnt_one;
            end
            // RAM data for a read issued this cycle is valid next cycle.
            r_inflight <= ren_b;
        end
    end

    stream_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (w_rst),
        .i_push  (r_inflight),
        .i_data  (dout_b),
        .i_pop   (w_pop),
        .o_data  (m_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule
`default_nettype wire
